rv32i_multicycle_ctrl: RTL

Multi-cycle control unit for the RV32I core. It sequences the existing single-cycle datapath through fetch, decode, execute, memory and writeback states, and handshakes with instruction and data memories that have variable latency. It holds the current instruction in an internal instruction register (IR) and drives every datapath control input: ALU op, immediate select, branch condition, register write enable, writeback mux select and PC enable. Supported instructions are R-type, OP-IMM, LW, SW and branches; every other encoding enters a sticky trap.

---
 rtl/rv32i_multicycle_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB with variable-latency
// memory handshakes, instruction register, datapath controls and a sticky illegal trap.
module rv32i_multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [31:0] ir,
  output logic [3:0]  alu_control,
  output logic        imm_sel,
  output logic [2:0]  branch_funct3,
  output logic        reg_we,
  output logic [1:0]  rd_sel,
  output logic        pc_en,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_ir;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_f7_zero;
  logic        w_f7_alt;
  logic        w_f3_altok;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_br;
  logic        w_legal;
  logic [3:0]  w_alu;
  logic        w_imm;

  assign w_opcode   = r_ir[6:0];
  assign w_funct3   = r_ir[14:12];
  assign w_funct7   = r_ir[31:25];
  assign w_f7_zero  = (w_funct7 == 7'b0000000);
  assign w_f7_alt   = (w_funct7 == 7'b0100000);
  assign w_f3_altok = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);

  assign w_is_r  = (w_opcode == 7'b0110011) && (w_f7_zero || (w_f7_alt && w_f3_altok));
  assign w_is_lw = (w_opcode == 7'b0000011) && (w_funct3 == 3'b010);
  assign w_is_sw = (w_opcode == 7'b0100011) && (w_funct3 == 3'b010);
  assign w_is_br = (w_opcode == 7'b1100011) && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
  assign w_legal = w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_br;

  // Only the shift-immediates constrain funct7; other OP-IMM funct7 bits are immediate.
  always_comb begin
    w_is_i = 1'b0;
    if (w_opcode == 7'b0010011) begin
      case (w_funct3)
        3'b001:  w_is_i = w_f7_zero;
        3'b101:  w_is_i = w_f7_zero || w_f7_alt;
        default: w_is_i = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_alu = '0;
    if (w_is_r)
      w_alu = {r_ir[30] & w_f3_altok, w_funct3};
    else if (w_is_i)
      w_alu = {r_ir[30] & (w_funct3 == 3'b101), w_funct3};
    else if (w_is_br)
      w_alu = 4'b1000;
  end

  assign w_imm = w_is_i || w_is_lw || w_is_sw;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (imem_ready) w_next = S_DECODE;
      S_DECODE:  w_next = w_legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE: w_next = (w_is_lw || w_is_sw) ? S_MEM : S_FETCH;
      S_MEM:     if (dmem_ready) w_next = w_is_sw ? S_FETCH : S_WB;
      S_WB:      w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && imem_ready)
        r_ir <= imem_rdata;
    end
  end

  // Reset overrides everything so a request in flight drops asynchronously.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    alu_control   = '0;
    imm_sel       = 1'b0;
    branch_funct3 = 3'b010;
    reg_we        = 1'b0;
    rd_sel        = 2'b00;
    pc_en         = 1'b0;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: imem_req = 1'b1;
      S_DECODE: begin
        alu_control = w_alu;
        imm_sel     = w_imm;
      end
      S_EXECUTE: begin
        alu_control = w_alu;
        imm_sel     = w_imm;
        if (w_is_br)
          branch_funct3 = w_funct3;
        reg_we = w_is_r || w_is_i;
        pc_en  = w_is_r || w_is_i || w_is_br;
      end
      S_MEM: begin
        alu_control = w_alu;
        imm_sel     = w_imm;
        dmem_req    = 1'b1;
        dmem_we     = w_is_sw;
        pc_en       = w_is_sw && dmem_ready;
      end
      S_WB: begin
        alu_control = w_alu;
        imm_sel     = w_imm;
        reg_we      = 1'b1;
        rd_sel      = 2'b01;
        pc_en       = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (reset) begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      alu_control   = '0;
      imm_sel       = 1'b0;
      branch_funct3 = 3'b010;
      reg_we        = 1'b0;
      rd_sel        = 2'b00;
      pc_en         = 1'b0;
      illegal       = 1'b0;
    end
  end

  assign ir = r_ir;

endmodule
